// File: rtl/dmem_pkg.sv
// Shared types and decode helpers for the two-slot data memory.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } dmem_state_e;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/dmem_2port_if.sv
// Request/response bundle for both slots of dmem_2port plus the shared ready.
interface dmem_2port_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
);
  logic              mem_ready;
  logic              req_valid_s0, req_valid_s1;
  logic              req_write_s0, req_write_s1;
  logic [2:0]        req_funct3_s0, req_funct3_s1;
  logic [ADDR_W-1:0] req_addr_s0, req_addr_s1;
  logic [XLEN-1:0]   req_wdata_s0, req_wdata_s1;
  logic              resp_valid_s0, resp_valid_s1;
  logic [XLEN-1:0]   resp_rdata_s0, resp_rdata_s1;
  logic              resp_err_s0, resp_err_s1;

  modport master (
    input  mem_ready,
    output req_valid_s0, req_valid_s1, req_write_s0, req_write_s1,
    output req_funct3_s0, req_funct3_s1, req_addr_s0, req_addr_s1,
    output req_wdata_s0, req_wdata_s1,
    input  resp_valid_s0, resp_valid_s1, resp_rdata_s0, resp_rdata_s1,
    input  resp_err_s0, resp_err_s1
  );

  modport slave (
    output mem_ready,
    input  req_valid_s0, req_valid_s1, req_write_s0, req_write_s1,
    input  req_funct3_s0, req_funct3_s1, req_addr_s0, req_addr_s1,
    input  req_wdata_s0, req_wdata_s1,
    output resp_valid_s0, resp_valid_s1, resp_rdata_s0, resp_rdata_s1,
    output resp_err_s0, resp_err_s1
  );
endinterface

// File: rtl/dmem_lane.sv
// Per-slot combinational decode: error check, row select, byte lanes for stores,
// and load extraction with sign/zero extension from a supplied row word.
module dmem_lane
  import dmem_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int DEPTH_BYTES = 4096,
  parameter int ADDR_W      = 64,
  parameter int ROW_W       = 9
) (
  input  logic [2:0]        funct3_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   row_data_i,
  output logic              err_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [XLEN/8-1:0] be_o,
  output logic [XLEN-1:0]   wlane_o,
  output logic [XLEN-1:0]   rdata_o
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_BYTES);

  logic [3:0]        size_s;
  logic [OFF_W-1:0]  off_s;
  logic [ADDR_W:0]   end_s;
  logic              mis_s, oor_s, ill_s;
  logic [NB-1:0]     be_base_s;
  logic [XLEN-1:0]   shifted_s, mask_s;
  logic              sign_s;

  // Request decode: checks, row index and store byte lanes.
  always_comb begin
    size_s = size_bytes(funct3_i);
    off_s  = addr_i[OFF_W-1:0];
    mis_s  = |(addr_i[3:0] & (size_s - 4'd1));
    end_s  = {1'b0, addr_i} + {{(ADDR_W-3){1'b0}}, size_s};
    oor_s  = (end_s > DEPTH_L);
    ill_s  = (write_i && funct3_i[2]) || (funct3_i == 3'b111) ||
             ((XLEN == 32) && ((funct3_i == F3_D) || (funct3_i == F3_WU)));
    err_o  = mis_s || oor_s || ill_s;
    row_o  = addr_i[OFF_W +: ROW_W];
    for (int i = 0; i < NB; i++) begin
      be_base_s[i] = (i < int'(size_s));
    end
    be_o    = be_base_s << off_s;
    wlane_o = wdata_i << {off_s, 3'b000};
  end

  // Load extraction; kept apart from decode so the row word can depend on row_o.
  always_comb begin
    shifted_s = row_data_i >> {off_s, 3'b000};
    for (int i = 0; i < XLEN; i++) begin
      mask_s[i] = (i < int'(size_s) * 8);
    end
    case (funct3_i[1:0])
      2'b00:   sign_s = shifted_s[7];
      2'b01:   sign_s = shifted_s[15];
      2'b10:   sign_s = shifted_s[31];
      default: sign_s = shifted_s[XLEN-1];
    endcase
    if (write_i || err_o) begin
      rdata_o = '0;
    end else if (sign_s && !funct3_i[2]) begin
      rdata_o = shifted_s | ~mask_s;
    end else begin
      rdata_o = shifted_s & mask_s;
    end
  end

endmodule

// File: rtl/dmem_2port.sv
// Two-slot data memory with same-cycle program-order resolution (slot 0 older).
// Optional DMEM_CLEAR_EN: zero the array row by row after every reset.
module dmem_2port
  import dmem_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int DEPTH_BYTES = 4096,
  parameter int ADDR_W      = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  dmem_2port_if.slave  bus
);
  localparam int NB    = XLEN / 8;
  localparam int ROWS  = DEPTH_BYTES / NB;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [XLEN-1:0]  mem_q [ROWS];
  logic             mem_ready_q;
  logic             resp_valid0_q, resp_valid1_q, resp_err0_q, resp_err1_q;
  logic [XLEN-1:0]  resp_rdata0_q, resp_rdata1_q;

  logic             acc0_s, acc1_s, we0_s, we1_s, err0_s, err1_s;
  logic [ROW_W-1:0] row0_s, row1_s;
  logic [NB-1:0]    be0_s, be1_s;
  logic [XLEN-1:0]  wlane0_s, wlane1_s, rdata0_s, rdata1_s, rd_row0_s, rd_row1_s;

  dmem_lane #(.XLEN(XLEN), .DEPTH_BYTES(DEPTH_BYTES), .ADDR_W(ADDR_W), .ROW_W(ROW_W)) u_lane0 (
    .funct3_i(bus.req_funct3_s0), .write_i(bus.req_write_s0), .addr_i(bus.req_addr_s0),
    .wdata_i(bus.req_wdata_s0), .row_data_i(rd_row0_s), .err_o(err0_s), .row_o(row0_s),
    .be_o(be0_s), .wlane_o(wlane0_s), .rdata_o(rdata0_s)
  );

  dmem_lane #(.XLEN(XLEN), .DEPTH_BYTES(DEPTH_BYTES), .ADDR_W(ADDR_W), .ROW_W(ROW_W)) u_lane1 (
    .funct3_i(bus.req_funct3_s1), .write_i(bus.req_write_s1), .addr_i(bus.req_addr_s1),
    .wdata_i(bus.req_wdata_s1), .row_data_i(rd_row1_s), .err_o(err1_s), .row_o(row1_s),
    .be_o(be1_s), .wlane_o(wlane1_s), .rdata_o(rdata1_s)
  );

  assign acc0_s = bus.req_valid_s0 && mem_ready_q && rst_n;
  assign acc1_s = bus.req_valid_s1 && mem_ready_q && rst_n;
  assign we0_s  = acc0_s && bus.req_write_s0 && !err0_s;
  assign we1_s  = acc1_s && bus.req_write_s1 && !err1_s;

  // Row reads; slot 1 sees slot 0's same-cycle store bytes, slot 0 sees old data.
  always_comb begin
    rd_row0_s = mem_q[row0_s];
    rd_row1_s = mem_q[row1_s];
    for (int b = 0; b < NB; b++) begin
      if (we0_s && (row0_s == row1_s) && be0_s[b]) begin
        rd_row1_s[b*8 +: 8] = wlane0_s[b*8 +: 8];
      end else begin
        rd_row1_s[b*8 +: 8] = mem_q[row1_s][b*8 +: 8];
      end
    end
  end

`ifdef DMEM_CLEAR_EN
  dmem_state_e      state_q;
  logic [ROW_W-1:0] clr_cnt_q;

  // Clear sequencer: one row per cycle from row 0, then RUN until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      mem_ready_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_cnt_q == ROW_W'(ROWS - 1)) begin
            state_q     <= RUN;
            mem_ready_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + ROW_W'(1);
          end
        end
        RUN:     mem_ready_q <= 1'b1;
        default: begin
          state_q     <= CLEAR;
          clr_cnt_q   <= '0;
          mem_ready_q <= 1'b0;
        end
      endcase
    end
  end
`else
  // Without the clear sequence the array is always ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready_q <= 1'b1;
    end else begin
      mem_ready_q <= 1'b1;
    end
  end
`endif

  // Array write port; slot 1 is applied last so its bytes win on overlap.
  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
    if (state_q == CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end
`endif
    for (int b = 0; b < NB; b++) begin
      if (we0_s && be0_s[b]) begin
        mem_q[row0_s][b*8 +: 8] <= wlane0_s[b*8 +: 8];
      end
      if (we1_s && be1_s[b]) begin
        mem_q[row1_s][b*8 +: 8] <= wlane1_s[b*8 +: 8];
      end
    end
  end

  // Response registers: one-cycle pulse per accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid0_q <= 1'b0;
      resp_valid1_q <= 1'b0;
      resp_err0_q   <= 1'b0;
      resp_err1_q   <= 1'b0;
      resp_rdata0_q <= '0;
      resp_rdata1_q <= '0;
    end else begin
      resp_valid0_q <= acc0_s;
      resp_valid1_q <= acc1_s;
      resp_err0_q   <= acc0_s && err0_s;
      resp_err1_q   <= acc1_s && err1_s;
      resp_rdata0_q <= acc0_s ? rdata0_s : '0;
      resp_rdata1_q <= acc1_s ? rdata1_s : '0;
    end
  end

  assign bus.mem_ready     = mem_ready_q;
  assign bus.resp_valid_s0 = resp_valid0_q;
  assign bus.resp_valid_s1 = resp_valid1_q;
  assign bus.resp_err_s0   = resp_err0_q;
  assign bus.resp_err_s1   = resp_err1_q;
  assign bus.resp_rdata_s0 = resp_rdata0_q;
  assign bus.resp_rdata_s1 = resp_rdata1_q;

endmodule

// File: tb/tb_dmem_2port.sv
// Directed bench for dmem_2port (XLEN=64, 64-byte array); follows DMEM_CLEAR_EN if defined.
module tb_dmem_2port;
  import dmem_pkg::*;

  localparam int XLEN  = 64;
  localparam int DEPTH = 64;
  localparam int AW    = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_2port_if #(.XLEN(XLEN), .ADDR_W(AW)) bus ();
  dmem_2port #(.XLEN(XLEN), .DEPTH_BYTES(DEPTH), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic        v, w;
    logic [2:0]  f;
    logic [63:0] a, d;
    logic        ev;
    logic [63:0] er;
    logic        ee;
  } slot_t;

  typedef struct {
    slot_t s0, s1;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rdy;
  bit   saw_resp;
  logic exp_rdy;

  function automatic slot_t sl(input logic w, input logic [2:0] f, input logic [63:0] a,
                               input logic [63:0] d, input logic [63:0] er, input logic ee);
    slot_t s;
    s.v = 1'b1; s.w = w; s.f = f; s.a = a; s.d = d; s.ev = 1'b1; s.er = er; s.ee = ee;
    return s;
  endfunction

  function automatic slot_t idle_sl();
    slot_t s;
    s.v = 1'b0; s.w = 1'b0; s.f = 3'b000; s.a = 64'h0; s.d = 64'h0;
    s.ev = 1'b0; s.er = 64'h0; s.ee = 1'b0;
    return s;
  endfunction

  task automatic chk(input string name, input logic [65:0] got, input logic [65:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.req_valid_s0  = v.s0.v; bus.req_write_s0 = v.s0.w; bus.req_funct3_s0 = v.s0.f;
    bus.req_addr_s0   = v.s0.a; bus.req_wdata_s0 = v.s0.d;
    bus.req_valid_s1  = v.s1.v; bus.req_write_s1 = v.s1.w; bus.req_funct3_s1 = v.s1.f;
    bus.req_addr_s1   = v.s1.a; bus.req_wdata_s1 = v.s1.d;
  endtask

  task automatic go_idle();
    vec_t v;
    v.s0 = idle_sl();
    v.s1 = idle_sl();
    apply(v);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    apply(v);
    @(posedge clk); #1;
    chk({name, "_s0"}, {bus.resp_valid_s0, bus.resp_err_s0, bus.resp_rdata_s0}, {v.s0.ev, v.s0.ee, v.s0.er});
    chk({name, "_s1"}, {bus.resp_valid_s1, bus.resp_err_s1, bus.resp_rdata_s1}, {v.s1.ev, v.s1.ee, v.s1.er});
  endtask

  // Counts edges until mem_ready is seen high (bounded), noting any response on the way.
  task automatic count_ready(output int n, output bit saw);
    n = 0;
    saw = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.mem_ready) begin
        n = k;
        break;
      end
      if (bus.resp_valid_s0 || bus.resp_valid_s1) saw = 1'b1;
    end
  endtask

  task automatic chk_outputs_reset(input string name);
    chk({name, "_flags"}, {61'h0, bus.mem_ready, bus.resp_valid_s0, bus.resp_err_s0, bus.resp_valid_s1, bus.resp_err_s1},
        {61'h0, exp_rdy, 4'b0000});
    chk({name, "_rdata"}, {2'b00, bus.resp_rdata_s0 | bus.resp_rdata_s1}, 66'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
`ifdef DMEM_CLEAR_EN
    exp_rdy = 1'b0;
`else
    exp_rdy = 1'b1;
`endif
    vecs[0]  = '{sl(1'b1, F3_D,  64'h10, 64'h8877665544332211, 64'h0, 1'b0),
                 sl(1'b1, F3_D,  64'h20, 64'h0, 64'h0, 1'b0)};
    vecs[1]  = '{sl(1'b0, F3_B,  64'h17, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0),
                 sl(1'b0, F3_BU, 64'h17, 64'h0, 64'h88, 1'b0)};
    vecs[2]  = '{sl(1'b0, F3_H,  64'h16, 64'h0, 64'hFFFFFFFFFFFF8877, 1'b0),
                 sl(1'b0, F3_WU, 64'h14, 64'h0, 64'h88776655, 1'b0)};
    vecs[3]  = '{sl(1'b1, F3_W,  64'h20, 64'hFFFFFFFFDEADBEEF, 64'h0, 1'b0),
                 sl(1'b0, F3_D,  64'h20, 64'h0, 64'h00000000DEADBEEF, 1'b0)};
    vecs[4]  = '{sl(1'b1, F3_B,  64'h30, 64'hAA, 64'h0, 1'b0),
                 sl(1'b1, F3_B,  64'h30, 64'hBB, 64'h0, 1'b0)};
    vecs[5]  = '{sl(1'b0, F3_BU, 64'h30, 64'h0, 64'hBB, 1'b0),
                 sl(1'b0, F3_W,  64'h14, 64'h0, 64'hFFFFFFFF88776655, 1'b0)};
    vecs[6]  = '{sl(1'b1, F3_D,  64'h38, 64'hCAFEF00D12345678, 64'h0, 1'b0),
                 sl(1'b1, F3_D,  64'h00, 64'h0, 64'h0, 1'b0)};
    vecs[7]  = '{sl(1'b0, F3_H,  64'h03, 64'h0, 64'h0, 1'b1),
                 sl(1'b1, F3_D,  64'h3C, 64'h1111111111111111, 64'h0, 1'b1)};
    vecs[8]  = '{sl(1'b1, 3'b100, 64'h00, 64'hFF, 64'h0, 1'b1),
                 sl(1'b0, F3_D,  64'h38, 64'h0, 64'hCAFEF00D12345678, 1'b0)};
    vecs[9]  = '{sl(1'b0, F3_D,  64'h00, 64'h0, 64'h0, 1'b0), idle_sl()};
    vecs[10] = '{sl(1'b0, F3_D,  64'h10, 64'h0, 64'h8877665544332211, 1'b0),
                 sl(1'b1, F3_D,  64'h10, 64'h0102030405060708, 64'h0, 1'b0)};
    vecs[11] = '{sl(1'b0, F3_D,  64'h10, 64'h0, 64'h0102030405060708, 1'b0),
                 sl(1'b0, F3_H,  64'h22, 64'h0, 64'hFFFFFFFFFFFFDEAD, 1'b0)};
    vecs[12] = '{sl(1'b0, F3_B,  64'h40, 64'h0, 64'h0, 1'b1),
                 sl(1'b0, F3_W,  64'h3C, 64'h0, 64'hFFFFFFFFCAFEF00D, 1'b0)};
    vecs[13] = '{sl(1'b1, F3_B,  64'h11, 64'h5A, 64'h0, 1'b0),
                 sl(1'b0, F3_D,  64'h10, 64'h0, 64'h0102030405065A08, 1'b0)};

    go_idle();
    repeat (2) @(negedge clk);
    chk_outputs_reset("reset_state");
    rst_n = 1'b1;

`ifdef DMEM_CLEAR_EN
    // Request held through the clear must be ignored, then taken once ready.
    vecs[0].s0 = vecs[0].s0;
    bus.req_valid_s0 = 1'b1; bus.req_write_s0 = 1'b0; bus.req_funct3_s0 = F3_D;
    bus.req_addr_s0 = 64'h38; bus.req_wdata_s0 = 64'h0;
    count_ready(n_rdy, saw_resp);
    chk("clear_cycles", 66'(n_rdy), 66'd8);
    chk("clear_no_resp", {65'h0, saw_resp}, 66'h0);
    @(posedge clk); #1;
    chk("ld_0x38_after_clear", {bus.resp_valid_s0, bus.resp_err_s0, bus.resp_rdata_s0}, {2'b10, 64'h0});
    go_idle();
`else
    count_ready(n_rdy, saw_resp);
    chk("ready_after_reset", 66'(n_rdy), 66'd1);
`endif

    for (int i = 0; i < NV; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end
    go_idle();

    // Reset while a response is being presented: it must vanish at once.
    bus.req_valid_s0 = 1'b1; bus.req_write_s0 = 1'b0; bus.req_funct3_s0 = F3_D; bus.req_addr_s0 = 64'h10;
    @(posedge clk); #1;
    chk("inflight_valid", {65'h0, bus.resp_valid_s0}, 66'h1);
    go_idle();
    rst_n = 1'b0;
    #1;
    chk_outputs_reset("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DMEM_CLEAR_EN
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_ready(n_rdy, saw_resp);
    chk("clear_restart_cycles", 66'(n_rdy), 66'd8);
    run_vec("ld_after_reclear", '{sl(1'b0, F3_D, 64'h10, 64'h0, 64'h0, 1'b0), idle_sl()});
`else
    count_ready(n_rdy, saw_resp);
    chk("ready_after_midop_reset", 66'(n_rdy), 66'd1);
    run_vec("ld_kept_across_reset",
            '{sl(1'b0, F3_D, 64'h10, 64'h0, 64'h0102030405065A08, 1'b0), idle_sl()});
`endif
    go_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_2port.md
# dmem_2port

Parametrised two-slot data memory for the 2-way superscalar core's memory stage. It accepts one load or store per slot per cycle, decoded with RISC-V funct3 encoding, and returns a registered, sign- or zero-extended result one cycle later. Same-cycle slot ordering is resolved in program order, with slot 0 older than slot 1. Misaligned and out-of-range accesses are flagged as errors. An optional post-reset clear sequence zeroes the array.

## Interface
Parameters:
- XLEN, 64, data width in bits; legal values are 32 or 64. With 32, LD, SD and LWU are illegal.
- DEPTH_BYTES, 4096, array size in bytes; power of two, multiple of XLEN/8.
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- mem_ready  out  1  array accepting requests; shared by both slots.
- req_valid_s0, req_valid_s1  in  1  request present on that slot.
- req_write_s0, req_write_s1  in  1  1 = store, 0 = load.
- req_funct3_s0, req_funct3_s1  in  3  RISC-V funct3 (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD).
- req_addr_s0, req_addr_s1  in  ADDR_W  byte address.
- req_wdata_s0, req_wdata_s1  in  XLEN  store data, LSB-aligned.
- resp_valid_s0, resp_valid_s1  out  1  response for the request accepted the previous cycle.
- resp_rdata_s0, resp_rdata_s1  out  XLEN  extended load data; 0 for stores and errors.
- resp_err_s0, resp_err_s1  out  1  misaligned, out-of-range, or illegal funct3.

## Operation
- A request is accepted on a rising edge when req_valid and mem_ready are both 1. mem_ready is 0 only in the CLEAR state.
- Access size comes from funct3[1:0]: 1, 2, 4 or 8 bytes. funct3[2] = 1 selects zero-extension on loads.
- Error conditions:
  - address not a multiple of the access size;
  - addr + size > DEPTH_BYTES;
  - store with funct3[2] = 1;
  - LD/SD/LWU when XLEN = 32.
- On error: no array write, resp_err = 1, rdata = 0.
- Storage is ROWS = DEPTH_BYTES/(XLEN/8) rows of XLEN bits with per-byte write enables. Aligned accesses never span rows.
- Same-cycle ordering rules:
  - Slot 0 store and slot 1 load with overlapping bytes: slot 1 returns the bytes written by slot 0, merged with the old contents.
  - Slot 0 load and slot 1 store to the same bytes: slot 0 returns the old data.
  - Both slots store to overlapping bytes: slot 1's bytes win.
- Stores produce resp_valid = 1 with rdata = 0 as an acknowledgment.
- State machine:
  - States: CLEAR and RUN.
  - CLEAR writes zero to row clr_cnt each cycle, with clr_cnt counting 0..ROWS-1.
  - After row ROWS-1 is written, the next state is RUN.
  - RUN is absorbing until reset.

## Timing
- Read latency is exactly 1 cycle: a request accepted at edge N gives resp_valid, rdata and err valid after edge N, held for one cycle only.
- Store data is visible to a load accepted at edge N+1 or later, and to a same-cycle slot 1 load as described under Operation.
- There is no response backpressure. The consumer must take the response in that cycle.
- Reset values: resp_valid_* = 0, resp_rdata_* = 0, resp_err_* = 0, clr_cnt = 0.
  - mem_ready = 0 after reset with DMEM_CLEAR_EN defined.
  - mem_ready = 1 after reset without it.
- Reset asserted mid-operation: outputs clear immediately and any in-flight response is dropped.
  - With DMEM_CLEAR_EN: the clear restarts from row 0.
  - Without DMEM_CLEAR_EN: array contents are untouched.
- A clear takes ROWS cycles after rst_n deasserts; mem_ready rises in cycle ROWS+1. Requests presented while mem_ready = 0 are ignored and produce no response.

## Configuration
- DMEM_CLEAR_EN defined: reset enters CLEAR and the array is zeroed as described above.
- DMEM_CLEAR_EN undefined:
  - reset enters RUN directly and the CLEAR state and clr_cnt are not built;
  - array contents are undefined after power-up and preserved across reset.

## Structure
- Package dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU;
  - the state enum {CLEAR, RUN};
  - a size-decode function (funct3 to byte count).
- One sub-module, dmem_lane, instantiated once per slot. It is combinational and computes:
  - the error flag;
  - the row index;
  - byte-enable and write-data lanes;
  - load extraction and sign/zero extension.
- The top level holds the array, the same-cycle merge logic, the FSM and the response registers.

## Test plan
- With DMEM_CLEAR_EN, DEPTH_BYTES = 64: release reset → mem_ready = 0 for 8 cycles, then 1. A following LD at 0x38 returns 0.
- SD 0x8877665544332211 at 0x10, then LB / LBU / LH / LWU at 0x17, 0x17, 0x16 and 0x14 on the next cycle:
  - LB at 0x17 → 0xFFFFFFFFFFFFFF88 would be returned if byte 0x17 were ≥ 0x80; here it is 0x88, so LB returns 0xFFFFFFFFFFFFFF88;
  - LBU at 0x17 → 0x88;
  - LH at 0x16 → 0xFFFFFFFFFFFF8877;
  - LWU at 0x14 → 0x88776655.
- Same cycle: s0 SW 0xDEADBEEF at 0x20, s1 LD at 0x20 over old zeros → s1 returns 0x00000000DEADBEEF. Same cycle: s0 SB 0xAA and s1 SB 0xBB at 0x30 → a later LBU at 0x30 returns 0xBB.
- Error cases:
  - LH at 0x3 → err = 1, rdata = 0;
  - SD at DEPTH_BYTES−4 → err = 1 and no bytes change;
  - store with funct3 = 100 → err = 1.
- With DMEM_CLEAR_EN: assert rst_n low at clear row 3 and release → clear restarts, full ROWS cycles.
  - Without the macro: reset after SD leaves the data readable, and mem_ready = 1 at the first edge after release.
